// File: rtl/riscv_perf_monitor_if.sv
// rtl/riscv_perf_monitor_if.sv - pipeline-to-monitor event and result bundle; stall signals exist only with PERF_STALL_CNT_EN
interface riscv_perf_monitor_if #(
  parameter int CNT_W = 32,
  parameter int BR_W  = 16
);
  logic             start;
  logic             retire_valid;
  logic             br_resolve;
  logic             br_mispredict;
  logic             halt_in;
  logic             done;
  logic [CNT_W-1:0] clock_count;
  logic [CNT_W-1:0] instr_count;
  logic [BR_W-1:0]  TotalBranches;
  logic [BR_W-1:0]  timeswrong;
  logic             cnt_ovf;
`ifdef PERF_STALL_CNT_EN
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output start, retire_valid, br_resolve, br_mispredict, halt_in, stall,
    input  done, clock_count, instr_count, TotalBranches, timeswrong, cnt_ovf, stall_count
  );
  modport slave (
    input  start, retire_valid, br_resolve, br_mispredict, halt_in, stall,
    output done, clock_count, instr_count, TotalBranches, timeswrong, cnt_ovf, stall_count
  );
`else
  modport master (
    output start, retire_valid, br_resolve, br_mispredict, halt_in,
    input  done, clock_count, instr_count, TotalBranches, timeswrong, cnt_ovf
  );
  modport slave (
    input  start, retire_valid, br_resolve, br_mispredict, halt_in,
    output done, clock_count, instr_count, TotalBranches, timeswrong, cnt_ovf
  );
`endif
endinterface

// File: rtl/riscv_perf_monitor.sv
// rtl/riscv_perf_monitor.sv - saturating cycle/instruction/branch counters with halt-drain end detection
// Optional stall counter enabled by defining PERF_STALL_CNT_EN.
module riscv_perf_monitor #(
  parameter int CNT_W        = 32,
  parameter int BR_W         = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input logic                   CLOCK_50,
  input logic                   rstn,
  riscv_perf_monitor_if.slave   pm
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [BR_W-1:0]  B_ONE      = BR_W'(1);
  localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t           state;
  logic [3:0]       drain_cnt;
  logic             active;
  logic [CNT_W-1:0] clk_nxt, instr_nxt;
  logic [BR_W-1:0]  tb_nxt, tw_nxt;
  logic             ovf_nxt;
`ifdef PERF_STALL_CNT_EN
  logic [CNT_W-1:0] stall_nxt;
`endif

  function automatic logic [CNT_W-1:0] sat_c(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + C_ONE;
  endfunction

  function automatic logic [BR_W-1:0] sat_b(input logic [BR_W-1:0] v);
    return (&v) ? v : v + B_ONE;
  endfunction

  // Counters only ever reach all-ones by incrementing, so an all-ones next value marks saturation.
  always_comb begin
    active    = (state == RUN) || (state == DRAIN);
    clk_nxt   = pm.clock_count;
    instr_nxt = pm.instr_count;
    tb_nxt    = pm.TotalBranches;
    tw_nxt    = pm.timeswrong;
    if (active) begin
      clk_nxt = sat_c(pm.clock_count);
      if (pm.retire_valid) instr_nxt = sat_c(pm.instr_count);
      if (pm.br_resolve) tb_nxt = sat_b(pm.TotalBranches);
      if (pm.br_resolve && pm.br_mispredict) tw_nxt = sat_b(pm.timeswrong);
    end
    ovf_nxt = pm.cnt_ovf | (&clk_nxt) | (&instr_nxt) | (&tb_nxt) | (&tw_nxt);
`ifdef PERF_STALL_CNT_EN
    stall_nxt = pm.stall_count;
    if (active && pm.stall) stall_nxt = sat_c(pm.stall_count);
    ovf_nxt = ovf_nxt | (&stall_nxt);
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      drain_cnt        <= 4'd0;
      pm.done          <= 1'b0;
      pm.clock_count   <= '0;
      pm.instr_count   <= '0;
      pm.TotalBranches <= '0;
      pm.timeswrong    <= '0;
      pm.cnt_ovf       <= 1'b0;
`ifdef PERF_STALL_CNT_EN
      pm.stall_count   <= '0;
`endif
    end else begin
      pm.clock_count   <= clk_nxt;
      pm.instr_count   <= instr_nxt;
      pm.TotalBranches <= tb_nxt;
      pm.timeswrong    <= tw_nxt;
      pm.cnt_ovf       <= ovf_nxt;
`ifdef PERF_STALL_CNT_EN
      pm.stall_count   <= stall_nxt;
`endif
      case (state)
        IDLE: if (pm.start) state <= RUN;
        RUN: begin
          if (pm.halt_in) begin
            if (DRAIN_CYCLES == 0) begin
              state   <= DONE;
              pm.done <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_INIT;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) begin
            state   <= DONE;
            pm.done <= 1'b1;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_perf_monitor.sv
// tb/tb_riscv_perf_monitor.sv - scoreboard bench for riscv_perf_monitor (BR_W=4, DRAIN_CYCLES=4)
module tb_riscv_perf_monitor;
  logic CLOCK_50 = 1'b0;
  logic rstn     = 1'b0;

  riscv_perf_monitor_if #(.CNT_W(32), .BR_W(4)) pm ();

  riscv_perf_monitor #(.CNT_W(32), .BR_W(4), .DRAIN_CYCLES(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .rstn     (rstn),
    .pm       (pm)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] clk_c;
    logic [31:0] instr_c;
    logic [31:0] stall_c;
    logic [3:0]  tb;
    logic [3:0]  tw;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rv, input logic br, input logic mp,
                       input logic h, input logic st);
    pm.start         = s;
    pm.retire_valid  = rv;
    pm.br_resolve    = br;
    pm.br_mispredict = mp;
    pm.halt_in       = h;
`ifdef PERF_STALL_CNT_EN
    pm.stall         = st;
`endif
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_done"},  pm.done, 0);
    check_val({tag, "_clk"},   pm.clock_count, 0);
    check_val({tag, "_instr"}, pm.instr_count, 0);
    check_val({tag, "_tb"},    pm.TotalBranches, 0);
    check_val({tag, "_tw"},    pm.timeswrong, 0);
    check_val({tag, "_ovf"},   pm.cnt_ovf, 0);
`ifdef PERF_STALL_CNT_EN
    check_val({tag, "_stall"}, pm.stall_count, 0);
`endif
  endtask

  task automatic score(input string tag);
    exp_t e;
    int   cyc = 0;
    while (!pm.done && cyc < 64) begin
      drive(0, 0, 0, 0, 0, 0);
      cyc++;
    end
    check_val({tag, "_done"}, pm.done, 1);
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_clk"},   pm.clock_count, e.clk_c);
      check_val({tag, "_instr"}, pm.instr_count, e.instr_c);
      check_val({tag, "_tb"},    pm.TotalBranches, e.tb);
      check_val({tag, "_tw"},    pm.timeswrong, e.tw);
      check_val({tag, "_ovf"},   pm.cnt_ovf, e.ovf);
`ifdef PERF_STALL_CNT_EN
      check_val({tag, "_stall"}, pm.stall_count, e.stall_c);
`endif
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge CLOCK_50);
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check_zero(tag);
    @(negedge CLOCK_50);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    pm.start = 0; pm.retire_valid = 0; pm.br_resolve = 0; pm.br_mispredict = 0; pm.halt_in = 0;
`ifdef PERF_STALL_CNT_EN
    pm.stall = 0;
`endif
    for (int i = 0; i < 5; i++) begin
      #10;
      pm.start = $urandom_range(0, 1); pm.retire_valid = $urandom_range(0, 1);
      pm.br_resolve = $urandom_range(0, 1); pm.br_mispredict = $urandom_range(0, 1);
      pm.halt_in = $urandom_range(0, 1);
`ifdef PERF_STALL_CNT_EN
      pm.stall = $urandom_range(0, 1);
`endif
    end
    check_zero("in_reset");
    @(negedge CLOCK_50);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLOCK_50);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) drive(0, 1, 1, 1, 1, 1);
    check_zero("idle");

    // start at edge 0, halt at 10 (and a stray halt at 12 inside DRAIN), retires at 1-10 and 12-13
    e = '{clk_c: 14, instr_c: 12, stall_c: 0, tb: 8, tw: 3, ovf: 0};
    sb_q.push_back(e);
    for (int t = 0; t <= 14; t++) begin
      drive(t == 0, (t >= 1 && t <= 10) || t == 12 || t == 13, t >= 1 && t <= 8,
            (t >= 1 && t <= 3) || t == 9 || t == 10, t == 10 || t == 12, 0);
      if (t == 13) check_val("basic_done_early", pm.done, 0);
    end
    score("basic");

    sb_q.push_back(e);
    for (int i = 0; i < 100; i++) drive(1, 1, 1, 1, 1, 1);
    score("freeze");

    apply_reset("rst_sat");
    sb_q.push_back('{clk_c: 24, instr_c: 0, stall_c: 0, tb: 15, tw: 15, ovf: 1});
    for (int t = 0; t <= 24; t++)
      drive(t == 0, 0, t >= 1 && t <= 20, t >= 1 && t <= 20, t == 20, 0);
    score("sat");

    apply_reset("rst_stall");
    sb_q.push_back('{clk_c: 10, instr_c: 0, stall_c: 5, tb: 0, tw: 0, ovf: 0});
    for (int t = 0; t <= 10; t++)
      drive(t == 0, 0, 0, 0, t == 6, t >= 2 && t <= 6);
    score("stall");

    apply_reset("rst_drain");
    for (int t = 0; t <= 5; t++)
      drive(t == 0, t >= 1 && t <= 3, 0, 0, t == 3, 0);
    check_val("drain_clk_mid", pm.clock_count, 5);
    check_val("drain_instr_mid", pm.instr_count, 3);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge CLOCK_50);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 1, 0, 0);
    check_zero("post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
